// File: rtl/invader_shot_scheduler.sv
// invader_shot_scheduler
//
// Schedules invader bomb firing. A pool of N_SLOTS bomb slots is shared by all
// invader columns; a frame-based cooldown spaces shots, and a one-column-per-
// cycle search picks a living column to fire from. Each pick is offered to the
// bomb datapath over a valid/ready handshake and is never retracted.
//
// Optional feature: define SHOT_RANDOM_EN to seed each search from an 8-bit
// Galois LFSR instead of the round-robin pointer.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   frame        in   one-cycle pulse at start of blanking
//   enable       in   firing allowed
//   alive_cols   in   [N_COLS]  column c has a living invader
//   slot_done    in   [N_SLOTS] per-slot pulse, bomb finished
//   spawn_ready  in   datapath accepts the spawn
//   spawn_valid  out  spawn request pending
//   spawn_col    out  [COL_W]   column to fire from
//   spawn_slot   out  [SLOT_W]  slot to use
//   slots_busy   out  [N_SLOTS] slot s holds a live bomb

module invader_shot_scheduler #(
    parameter int unsigned N_COLS          = 6,
    parameter int unsigned COL_W           = 3,
    parameter int unsigned N_SLOTS         = 3,
    parameter int unsigned SLOT_W          = 2,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame,
    input  logic                enable,
    input  logic [N_COLS-1:0]   alive_cols,
    input  logic [N_SLOTS-1:0]  slot_done,
    input  logic                spawn_ready,
    output logic                spawn_valid,
    output logic [COL_W-1:0]    spawn_col,
    output logic [SLOT_W-1:0]   spawn_slot,
    output logic [N_SLOTS-1:0]  slots_busy
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SEARCH = 2'd1,
        S_ISSUE  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          cd_q, cd_d;
    logic [COL_W-1:0]    ptr_q, ptr_d;
    logic [COL_W-1:0]    idx_q, idx_d;
    logic [COL_W:0]      miss_q, miss_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                spawn_valid_q, spawn_valid_d;
    logic [COL_W-1:0]    spawn_col_q, spawn_col_d;
    logic [SLOT_W-1:0]   spawn_slot_q, spawn_slot_d;
    logic [N_SLOTS-1:0]  slots_busy_q, slots_busy_d;

    logic [COL_W-1:0]    start_col;
    logic [SLOT_W-1:0]   free_slot;
    logic                can_fire;
    logic                accept;

`ifdef SHOT_RANDOM_EN
    logic [7:0]          lfsr_q, lfsr_d;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end

    // Out-of-range random columns fold to column 0.
    always_comb begin
        if (32'(lfsr_q[COL_W-1:0]) >= N_COLS) begin
            start_col = '0;
        end else begin
            start_col = lfsr_q[COL_W-1:0];
        end
    end
`else
    always_comb begin
        start_col = ptr_q;
    end
`endif

    // Lowest-numbered clear slot; scanning downward lets the lowest win.
    always_comb begin
        free_slot = '0;
        for (int unsigned s = N_SLOTS; s > 0; s--) begin
            if (!slots_busy_q[s-1]) begin
                free_slot = SLOT_W'(s - 1);
            end
        end
    end

    always_comb begin
        can_fire = (cd_q == 8'd0) && enable && (alive_cols != '0) && !(&slots_busy_q);
        accept   = (state_q == S_ISSUE) && spawn_ready;
    end

    always_comb begin
        state_d       = state_q;
        cd_d          = cd_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        miss_d        = miss_q;
        slot_d        = slot_q;
        spawn_valid_d = spawn_valid_q;
        spawn_col_d   = spawn_col_q;
        spawn_slot_d  = spawn_slot_q;

        // Done pulses on already-clear slots are harmless here; a set from
        // an acceptance below is applied after the clear.
        slots_busy_d  = slots_busy_q & ~slot_done;

        // Reload on acceptance takes priority over a coincident frame.
        if (accept) begin
            cd_d = 8'(COOLDOWN_FRAMES);
        end else if (frame && enable && (cd_q != 8'd0)) begin
            cd_d = cd_q - 8'd1;
        end

        case (state_q)
            S_WAIT: begin
                if (can_fire) begin
                    state_d = S_SEARCH;
                    idx_d   = start_col;
                    miss_d  = '0;
                    slot_d  = free_slot;
                end
            end

            S_SEARCH: begin
                if (!enable) begin
                    state_d = S_WAIT;
                end else if (alive_cols[idx_q]) begin
                    spawn_col_d   = idx_q;
                    spawn_slot_d  = slot_q;
                    spawn_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end else begin
                    idx_d  = (idx_q == COL_W'(N_COLS - 1)) ? '0 : idx_q + COL_W'(1);
                    miss_d = miss_q + (COL_W+1)'(1);
                    if (miss_q == (COL_W+1)'(N_COLS - 1)) begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_ISSUE: begin
                if (spawn_ready) begin
                    slots_busy_d[spawn_slot_q] = 1'b1;
                    ptr_d         = (spawn_col_q == COL_W'(N_COLS - 1)) ? '0
                                                                        : spawn_col_q + COL_W'(1);
                    spawn_valid_d = 1'b0;
                    state_d       = S_WAIT;
                end
            end

            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_WAIT;
            cd_q          <= 8'(COOLDOWN_FRAMES);
            ptr_q         <= '0;
            idx_q         <= '0;
            miss_q        <= '0;
            slot_q        <= '0;
            spawn_valid_q <= 1'b0;
            spawn_col_q   <= '0;
            spawn_slot_q  <= '0;
            slots_busy_q  <= '0;
`ifdef SHOT_RANDOM_EN
            lfsr_q        <= 8'hA5;
`endif
        end else begin
            state_q       <= state_d;
            cd_q          <= cd_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            miss_q        <= miss_d;
            slot_q        <= slot_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_col_q   <= spawn_col_d;
            spawn_slot_q  <= spawn_slot_d;
            slots_busy_q  <= slots_busy_d;
`ifdef SHOT_RANDOM_EN
            lfsr_q        <= lfsr_d;
`endif
        end
    end

    assign spawn_valid = spawn_valid_q;
    assign spawn_col   = spawn_col_q;
    assign spawn_slot  = spawn_slot_q;
    assign slots_busy  = slots_busy_q;

endmodule

// File: tb/tb_invader_shot_scheduler.sv
// tb_invader_shot_scheduler
//
// Bench for invader_shot_scheduler with a 2-frame cooldown. Expected spawns
// (column, slot) are queued as each scenario is set up and compared when the
// handshake completes; other outputs are compared directly at known points.

module tb_invader_shot_scheduler;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       enable;
    logic [5:0] alive_cols;
    logic [2:0] slot_done;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [2:0] spawn_col;
    logic [1:0] spawn_slot;
    logic [2:0] slots_busy;

    typedef struct packed {
        logic [2:0] col;
        logic [1:0] slot;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_spawns = 0;

    invader_shot_scheduler #(
        .N_COLS(6),
        .COL_W(3),
        .N_SLOTS(3),
        .SLOT_W(2),
        .COOLDOWN_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame(frame),
        .enable(enable),
        .alive_cols(alive_cols),
        .slot_done(slot_done),
        .spawn_ready(spawn_ready),
        .spawn_valid(spawn_valid),
        .spawn_col(spawn_col),
        .spawn_slot(spawn_slot),
        .slots_busy(slots_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Scoreboard: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && spawn_valid && spawn_ready) begin
            exp_t e;
            n_spawns++;
            check_eq("sb_avail", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("spawn_col", int'(spawn_col), int'(e.col));
                check_eq("spawn_slot", int'(spawn_slot), int'(e.slot));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick();
        frame = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] col, input logic [1:0] slot);
        exp_t e;
        e.col  = col;
        e.slot = slot;
        exp_q.push_back(e);
    endtask

    task automatic wait_spawns(input int target);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (n_spawns >= target) break;
        end
        check_eq("spawn_count", n_spawns, target);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (spawn_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        int base;

        rst         = 1'b1;
        frame       = 1'b0;
        enable      = 1'b1;
        alive_cols  = 6'b111111;
        slot_done   = 3'b000;
        spawn_ready = 1'b1;

        // Reset state and first spawn after two frames.
        tick();
        @(negedge clk);
        check_eq("rst_valid", int'(spawn_valid), 0);
        check_eq("rst_col", int'(spawn_col), 0);
        check_eq("rst_slot", int'(spawn_slot), 0);
        check_eq("rst_busy", int'(slots_busy), 0);
        tick();
        rst = 1'b0;
        pulse_frame();
        repeat (8) tick();
        check_eq("no_early_spawn", n_spawns, 0);
        push_exp(3'd0, 2'd0);
        pulse_frame();
        wait_spawns(1);
        check_eq("busy_first", int'(slots_busy), 3'b001);

        // Round-robin over sparse columns: 2, 5, 2 into slots 0, 1, 2.
        do_reset();
        alive_cols = 6'b100100;
        base = n_spawns;
        push_exp(3'd2, 2'd0);
        pulse_frame();
        pulse_frame();
        wait_valid(lat);
        check_eq("search_latency", lat, 4);
        wait_spawns(base + 1);
        push_exp(3'd5, 2'd1);
        pulse_frame();
        pulse_frame();
        wait_spawns(base + 2);
        push_exp(3'd2, 2'd2);
        pulse_frame();
        pulse_frame();
        wait_spawns(base + 3);
        check_eq("busy_full", int'(slots_busy), 3'b111);
        pulse_frame();
        pulse_frame();
        pulse_frame();
        repeat (12) tick();
        check_eq("no_fourth", n_spawns, base + 3);

        // Freeing slot 1 with cooldown already expired.
        push_exp(3'd5, 2'd1);
        slot_done = 3'b010;
        tick();
        slot_done = 3'b000;
        check_eq("busy_after_done", int'(slots_busy), 3'b101);
        wait_spawns(base + 4);
        check_eq("busy_refill", int'(slots_busy), 3'b111);

        // Back-pressure: request held stable, no retraction on enable drop.
        slot_done = 3'b001;
        tick();
        slot_done = 3'b000;
        spawn_ready = 1'b0;
        push_exp(3'd2, 2'd0);
        pulse_frame();
        pulse_frame();
        wait_valid(lat);
        check_eq("hold_seen", int'(lat != 0), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", int'(spawn_valid), 1);
            check_eq("hold_col", int'(spawn_col), 2);
            check_eq("hold_slot", int'(spawn_slot), 0);
            tick();
            if (i == 1) enable = 1'b0;
        end
        check_eq("hold_no_xfer", n_spawns, base + 4);
        spawn_ready = 1'b1;
        wait_spawns(base + 5);
        check_eq("busy_after_hold", int'(slots_busy), 3'b111);
        enable = 1'b1;

        // Columns die mid-search: full miss sweep, then immediate spawn.
        do_reset();
        base = n_spawns;
        alive_cols = 6'b100000;
        pulse_frame();
        pulse_frame();
        tick();
        alive_cols = 6'b000000;
        repeat (12) tick();
        check_eq("dead_no_spawn", n_spawns, base);
        check_eq("dead_no_valid", int'(spawn_valid), 0);
        push_exp(3'd0, 2'd0);
        alive_cols = 6'b000001;
        wait_spawns(base + 1);

        // Reset while a spawn is pending.
        alive_cols = 6'b111111;
        push_exp(3'd1, 2'd1);
        pulse_frame();
        pulse_frame();
        wait_spawns(base + 2);
        check_eq("busy_pre_rst", int'(slots_busy), 3'b011);
        spawn_ready = 1'b0;
        pulse_frame();
        pulse_frame();
        wait_valid(lat);
        check_eq("pend_valid", int'(spawn_valid), 1);
        rst         = 1'b1;
        spawn_ready = 1'b1;
        slot_done   = 3'b001;
        tick();
        rst       = 1'b0;
        slot_done = 3'b000;
        check_eq("rst2_valid", int'(spawn_valid), 0);
        check_eq("rst2_col", int'(spawn_col), 0);
        check_eq("rst2_slot", int'(spawn_slot), 0);
        check_eq("rst2_busy", int'(slots_busy), 0);
        pulse_frame();
        repeat (8) tick();
        check_eq("rst2_cd_hold", n_spawns, base + 2);
        push_exp(3'd0, 2'd0);
        pulse_frame();
        wait_spawns(base + 3);

        repeat (3) tick();
        check_eq("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
